alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/btn_pulse.sv | 42 ++++
 rtl/alu_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the switch-driven ALU sequencer:
// op codes, controller state encoding and flag bit positions.
package alu_pkg;

    // Controller states, encoded as reported on state_o
    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_WAIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // ALU op codes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SLL  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_SUB  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    // Flag word layout {ZF,CF,OF,SF}
    localparam int ZF_BIT = 3;
    localparam int CF_BIT = 2;
    localparam int OF_BIT = 1;
    localparam int SF_BIT = 0;

    // Width of the ALU latency counter (latency up to 15)
    localparam int CNT_W = 4;

    // Legal op codes run from ADD through SRA
    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_SRA;
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button synchronizer and rising-edge detector producing
// one-cycle pulses; a level held through reset never pulses.
module btn_pulse #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic [STAGES-1:0] sync;
    logic [STAGES-1:0] fill;
    logic              prev;
    logic              armed;

    // Sync chain, fill tracker, edge history and arming flag.
    // The detector arms only after a valid low level is seen,
    // so a button pressed during reset must be released first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            fill  <= '0;
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync[0] <= btn;
            fill[0] <= 1'b1;
            for (int i = 1; i < STAGES; i++) begin
                sync[i] <= sync[i-1];
                fill[i] <= fill[i-1];
            end
            prev <= sync[STAGES-1];
            if (fill[STAGES-1] && !sync[STAGES-1]) begin
                armed <= 1'b1;
            end
        end
    end

    assign pulse = sync[STAGES-1] & ~prev & armed;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Step-button sequencer: loads A, B and op from switches,
// waits out the ALU latency and captures result and flags.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] SW,
    input  logic        btn_step,
    input  logic        btn_half,
    input  logic [31:0] alu_res,
    input  logic [3:0]  alu_flags,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [31:0] res_q,
    output logic [3:0]  F,
    output logic [15:0] disp_word,
    output logic [2:0]  state_o,
    output logic        busy,
    output logic        err
);

    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_chk
        $error("ALU_LAT out of range 1..15");
    end

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LAT - 1);

    state_t           st;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             half;
    logic             step_p;
    logic             half_p;

    btn_pulse #(
        .STAGES (SYNC_STAGES)
    ) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_step),
        .pulse (step_p)
    );

    btn_pulse #(
        .STAGES (SYNC_STAGES)
    ) u_half (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_half),
        .pulse (half_p)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= S_LOAD_A;
        end else begin
            st <= nxt;
        end
    end

    // Next-state logic; steps in EXEC/WAIT are simply dropped
    always_comb begin
        nxt = st;
        unique case (st)
            S_LOAD_A: begin
                if (step_p) nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                if (step_p) nxt = S_LOAD_OP;
            end
            S_LOAD_OP: begin
                if (step_p) begin
                    nxt = op_legal(SW[3:0]) ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) nxt = S_DONE;
            end
            S_DONE: begin
                if (step_p) nxt = S_LOAD_A;
            end
            default: begin
                nxt = S_LOAD_A;
            end
        endcase
    end

    // State-derived outputs
    always_comb begin
        state_o = st;
        busy    = (st == S_EXEC) || (st == S_WAIT);
    end

    // Operand/op loads, latency counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            res_q  <= '0;
            F      <= '0;
            err    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (st)
                S_LOAD_A: begin
                    if (step_p) alu_a <= SW;
                end
                S_LOAD_B: begin
                    if (step_p) alu_b <= SW;
                end
                S_LOAD_OP: begin
                    if (step_p) begin
                        alu_op <= SW[3:0];
                        if (!op_legal(SW[3:0])) begin
                            res_q <= '0;
                            F     <= '0;
                            err   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    cnt <= LAT_M1;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        res_q <= alu_res;
                        F     <= alu_flags;
                        err   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Display half select toggles in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half <= 1'b0;
        end else if (half_p) begin
            half <= ~half;
        end
    end

    assign disp_word = half ? res_q[31:16] : res_q[15:0];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: pipelined ALU model, vector table
// with scoreboard, plus latency, busy-step and reset sequences.
module tb_alu_seq_ctrl;

    localparam int LAT = 3;
    localparam int SS  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] SW = '0;
    logic        btn_step = 1'b0;
    logic        btn_half = 1'b0;
    logic [31:0] alu_res;
    logic [3:0]  alu_flags;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] res_q;
    logic [3:0]  F;
    logic [15:0] disp_word;
    logic [2:0]  state_o;
    logic        busy;
    logic        err;

    alu_seq_ctrl #(
        .ALU_LAT     (LAT),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SW        (SW),
        .btn_step  (btn_step),
        .btn_half  (btn_half),
        .alu_res   (alu_res),
        .alu_flags (alu_flags),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .res_q     (res_q),
        .F         (F),
        .disp_word (disp_word),
        .state_o   (state_o),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ALU model with LAT register stages
    function automatic void alu_fn(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [3:0]  op,
                                   output logic [31:0] r,
                                   output logic [3:0]  f);
        logic [32:0] w;
        logic c;
        logic o;
        c = 1'b0;
        o = 1'b0;
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: r = a << b[4:0];
            4'd2: r = {31'b0, $signed(a) < $signed(b)};
            4'd3: r = {31'b0, a < b};
            4'd4: r = a ^ b;
            4'd5: r = a >> b[4:0];
            4'd6: r = a | b;
            4'd7: r = a & b;
            4'd8: begin
                r = a - b;
                c = a < b;
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd9: r = $unsigned($signed(a) >>> b[4:0]);
            default: r = 32'h0BAD_0BAD;
        endcase
        f = {r == 32'b0, c, o, r[31]};
    endfunction

    logic [31:0] pr [LAT];
    logic [3:0]  pf [LAT];
    logic [31:0] cr;
    logic [3:0]  cf;

    always_comb alu_fn(alu_a, alu_b, alu_op, cr, cf);

    always @(posedge clk) begin
        pr[0] <= cr;
        pf[0] <= cf;
        for (int i = 1; i < LAT; i++) begin
            pr[i] <= pr[i-1];
            pf[i] <= pf[i-1];
        end
    end

    assign alu_res   = pr[LAT-1];
    assign alu_flags = pf[LAT-1];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic [3:0]  f;
        logic        e;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  f;
        logic        e;
    } exp_t;

    exp_t sb [$];
    vec_t tv [14];
    int   total = 0;
    int   bad = 0;
    logic half_exp = 1'b0;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        btn_step = 1'b1;
        cyc(4);
        btn_step = 1'b0;
        cyc(4);
    endtask

    task automatic press_half();
        btn_half = 1'b1;
        cyc(4);
        btn_half = 1'b0;
        cyc(4);
        half_exp = ~half_exp;
    endtask

    task automatic press_both();
        btn_step = 1'b1;
        btn_half = 1'b1;
        cyc(4);
        btn_step = 1'b0;
        btn_half = 1'b0;
        cyc(4);
        half_exp = ~half_exp;
    endtask

    task automatic wait_st(input logic [2:0] s,
                           input int max,
                           input string nm);
        int k;
        k = 0;
        while (state_o !== s && k < max) begin
            cyc(1);
            k++;
        end
        check(nm, {29'b0, state_o}, {29'b0, s});
    endtask

    task automatic check_done(input string nm);
        exp_t e;
        logic [15:0] d;
        if (sb.size() == 0) begin
            check({nm, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            d = half_exp ? e.res[31:16] : e.res[15:0];
            check({nm, "_res"}, res_q, e.res);
            check({nm, "_flags"}, {28'b0, F}, {28'b0, e.f});
            check({nm, "_err"}, {31'b0, err}, {31'b0, e.e});
            check({nm, "_disp"}, {16'b0, disp_word}, {16'b0, d});
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        SW = v.a;
        press();
        SW = v.b;
        press();
        SW = {28'b0, v.op};
        sb.push_back('{v.res, v.f, v.e});
        press();
        wait_st(3'd5, 20, {nm, "_done"});
        check_done(nm);
    endtask

    initial begin
        exp_t drop;
        tv[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 32'hFFFF_FFFE, 4'b0101, 1'b0};
        tv[1]  = '{32'h0000_0001, 32'h0000_0002, 4'd1, 32'h0000_0004, 4'b0000, 1'b0};
        tv[2]  = '{32'hA000_0001, 32'h0000_0001, 4'd2, 32'h0000_0001, 4'b0000, 1'b0};
        tv[3]  = '{32'h0000_0002, 32'h0000_0001, 4'd2, 32'h0000_0000, 4'b1000, 1'b0};
        tv[4]  = '{32'h1234_5678, 32'h0000_0001, 4'd12, 32'h0000_0000, 4'b0000, 1'b1};
        tv[5]  = '{32'h0000_0005, 32'h0000_0003, 4'd3, 32'h0000_0000, 4'b1000, 1'b0};
        tv[6]  = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd4, 32'hFFFF_FFFF, 4'b0001, 1'b0};
        tv[7]  = '{32'h8000_0000, 32'h0000_0004, 4'd5, 32'h0800_0000, 4'b0000, 1'b0};
        tv[8]  = '{32'h1234_0000, 32'h0000_5678, 4'd6, 32'h1234_5678, 4'b0000, 1'b0};
        tv[9]  = '{32'hFF00_FF00, 32'h0F0F_0F0F, 4'd7, 32'h0F00_0F00, 4'b0000, 1'b0};
        tv[10] = '{32'h0000_0003, 32'h0000_0005, 4'd8, 32'hFFFF_FFFE, 4'b0101, 1'b0};
        tv[11] = '{32'h8000_0000, 32'h0000_0004, 4'd9, 32'hF800_0000, 4'b0001, 1'b0};
        tv[12] = '{32'h0000_0001, 32'h0000_0001, 4'd15, 32'h0000_0000, 4'b0000, 1'b1};
        tv[13] = '{32'h0000_0007, 32'h0000_0007, 4'd8, 32'h0000_0000, 4'b1000, 1'b0};

        cyc(3);
        check("rst_state", {29'b0, state_o}, 32'd0);
        check("rst_a", alu_a, 32'd0);
        check("rst_b", alu_b, 32'd0);
        check("rst_op", {28'b0, alu_op}, 32'd0);
        check("rst_res", res_q, 32'd0);
        check("rst_f", {28'b0, F}, 32'd0);
        check("rst_err_busy", {30'b0, err, busy}, 32'd0);
        check("rst_disp", {16'b0, disp_word}, 32'd0);
        rst_n = 1'b1;
        cyc(5);

        // Load latency: register update on the third edge
        SW = 32'hDEAD_BEEF;
        btn_step = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("lat_early", {29'b0, state_o}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_state", {29'b0, state_o}, 32'd1);
        check("lat_a", alu_a, 32'hDEAD_BEEF);
        cyc(3);
        btn_step = 1'b0;
        cyc(4);
        SW = 32'd1;
        press();
        SW = 32'd12;
        press();
        check("ill_state", {29'b0, state_o}, 32'd5);
        check("ill_err", {31'b0, err}, 32'd1);
        press();
        check("back_load_a", {29'b0, state_o}, 32'd0);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            run_op(tv[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                press_half();
                check("half_toggle", {16'b0, disp_word}, 32'h0000_FFFF);
            end
            if (i == 1) begin
                press_both();
                check("both_state", {29'b0, state_o}, 32'd0);
                check("both_disp", {16'b0, disp_word}, 32'h0000_0004);
            end else begin
                press();
            end
        end

        // Step during WAIT is ignored; DONE 4 cycles after EXEC
        SW = 32'd10;
        press();
        SW = 32'd20;
        press();
        SW = 32'd0;
        sb.push_back('{32'd30, 4'b0000, 1'b0});
        btn_step = 1'b1;
        wait_st(3'd3, 10, "s5_exec");
        btn_step = 1'b0;
        cyc(1);
        check("s5_wait1", {29'b0, state_o, busy}, {28'b0, 3'd4, 1'b1});
        btn_step = 1'b1;
        cyc(1);
        check("s5_wait2", {29'b0, state_o}, 32'd4);
        cyc(1);
        check("s5_wait3", {29'b0, state_o}, 32'd4);
        cyc(1);
        check("s5_done4", {29'b0, state_o, busy}, {28'b0, 3'd5, 1'b0});
        check_done("s5");
        cyc(6);
        check("s5_no_queue", {29'b0, state_o}, 32'd5);
        btn_step = 1'b0;
        cyc(4);
        press();

        // Reset during WAIT with step held through reset
        SW = 32'd1;
        press();
        SW = 32'd1;
        press();
        SW = 32'd0;
        sb.push_back('{32'd2, 4'b0000, 1'b0});
        btn_step = 1'b1;
        wait_st(3'd3, 10, "s6_exec");
        cyc(1);
        rst_n = 1'b0;
        half_exp = 1'b0;
        #1;
        drop = sb.pop_front();
        check("s6_rst_state", {29'b0, state_o, busy}, 32'd0);
        check("s6_rst_ab", alu_a | alu_b, 32'd0);
        check("s6_rst_res", res_q, 32'd0);
        check("s6_rst_misc", {23'b0, alu_op, F, err}, 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        check("s6_no_capture", res_q, 32'd0);
        check("s6_held_state", {29'b0, state_o}, 32'd0);
        check("s6_held_a", alu_a, 32'd0);
        btn_step = 1'b0;
        cyc(4);
        SW = 32'd55;
        press();
        check("s6_repress_state", {29'b0, state_o}, 32'd1);
        check("s6_repress_a", alu_a, 32'd55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
